// File: rtl/mips_mc_pkg.sv
// Shared constants and types for the multi-cycle MIPS controller:
// opcode/funct encodings, FSM states, ALU op codes and mux select codes.
package mips_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_OR   = 3'd2;
  localparam logic [2:0] ALU_SLT  = 3'd3;
  localparam logic [2:0] ALU_LUI  = 3'd4;

  localparam logic [1:0] NPC_ALU    = 2'b00;
  localparam logic [1:0] NPC_ALUOUT = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BOFF  = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_EXE_R, S_EXE_I, S_ALU_WB, S_BRANCH, S_JUMP, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    CLS_MEM, CLS_R, CLS_I, CLS_BEQ, CLS_J, CLS_ILL
  } cls_t;

  typedef struct packed {
    cls_t       cls;
    logic       is_load;
    logic [2:0] alu_op;
    logic       legal;
  } dec_t;

endpackage

// File: rtl/mips_mc_decode.sv
// Combinational instruction classifier: maps IR opcode/funct to an
// instruction class, the execute-stage ALU op and a legal flag.
module mips_mc_decode
  import mips_mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output dec_t       dec
);

  always_comb begin
    dec.cls     = CLS_ILL;
    dec.is_load = 1'b0;
    dec.alu_op  = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        dec.cls = CLS_R;
        case (funct)
          FN_ADDU: dec.alu_op = ALU_ADD;
          FN_SUBU: dec.alu_op = ALU_SUB;
          FN_SLT:  dec.alu_op = ALU_SLT;
          default: dec.cls    = CLS_ILL;
        endcase
      end
      OP_ORI: begin dec.cls = CLS_I; dec.alu_op = ALU_OR;  end
      OP_LUI: begin dec.cls = CLS_I; dec.alu_op = ALU_LUI; end
      OP_LW:  begin dec.cls = CLS_MEM; dec.is_load = 1'b1; end
      OP_SW:  dec.cls = CLS_MEM;
      OP_BEQ: dec.cls = CLS_BEQ;
      OP_J:   dec.cls = CLS_J;
      default: dec.cls = CLS_ILL;
    endcase
    dec.legal = (dec.cls != CLS_ILL);
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Moore control FSM for the multi-cycle MIPS datapath with memory wait
// handshake and illegal-opcode trap. MIPS_MC_PERF_CNT_EN adds cycle/retire counters.
module mips_mc_ctrl
  import mips_mc_pkg::*;
#(
  parameter int ALU_CTL_W = 3,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic [1:0]           npc_sel,
  output logic                 ir_write,
  output logic                 iord,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 reg_write,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic                 ext_op,
  output logic [ALU_CTL_W-1:0] alu_ctl,
  output logic                 instr_retired,
  output logic                 illegal,
`ifdef MIPS_MC_PERF_CNT_EN
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     instr_cnt,
`endif
  output logic [3:0]           state_dbg
);

  state_t     state, next_state;
  dec_t       dec;
  logic [2:0] alu_op;

  mips_mc_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .dec    (dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

  always_comb begin
    next_state    = state;
    pc_write      = 1'b0;
    npc_sel       = NPC_ALU;
    ir_write      = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_FOUR;
    ext_op        = 1'b0;
    alu_op        = ALU_ADD;
    instr_retired = 1'b0;
    illegal       = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_BOFF;
        ext_op    = 1'b1;
        case (dec.cls)
          CLS_MEM: next_state = S_MEM_ADDR;
          CLS_R:   next_state = S_EXE_R;
          CLS_I:   next_state = S_EXE_I;
          CLS_BEQ: next_state = S_BRANCH;
          CLS_J:   next_state = S_JUMP;
          default: next_state = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        ext_op     = 1'b1;
        next_state = dec.is_load ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) next_state = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write     = 1'b1;
        mem_to_reg    = 1'b1;
        instr_retired = 1'b1;
        next_state    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          instr_retired = 1'b1;
          next_state    = S_FETCH;
        end
      end
      S_EXE_R: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_RT;
        alu_op     = dec.alu_op;
        next_state = S_ALU_WB;
      end
      S_EXE_I: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        alu_op     = dec.alu_op;
        next_state = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write     = 1'b1;
        reg_dst       = (dec.cls == CLS_R);
        instr_retired = 1'b1;
        next_state    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_RT;
        alu_op        = ALU_SUB;
        npc_sel       = NPC_ALUOUT;
        pc_write      = zero;
        instr_retired = 1'b1;
        next_state    = S_FETCH;
      end
      S_JUMP: begin
        pc_write      = 1'b1;
        npc_sel       = NPC_JUMP;
        instr_retired = 1'b1;
        next_state    = S_FETCH;
      end
      S_TRAP:  illegal    = 1'b1;
      default: next_state = S_FETCH;
    endcase
    // Reset forces state to FETCH asynchronously; also silence every
    // request so an in-flight memory write is dropped immediately.
    if (rst) begin
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      instr_retired = 1'b0;
      illegal       = 1'b0;
    end
  end

  assign alu_ctl   = ALU_CTL_W'(alu_op);
  assign state_dbg = state;

`ifdef MIPS_MC_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else if (state != S_TRAP) begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (instr_retired) instr_cnt <= instr_cnt + 1'b1;
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: random instruction stream with planned
// memory stalls; a negedge monitor checks per-instruction behaviour on retire.
module tb_mips_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0, funct = '0;
  logic       zero = 1'b0, mem_ready = 1'b0;
  logic       pc_write, ir_write, iord, mem_read, mem_write, reg_write;
  logic       reg_dst, mem_to_reg, alu_src_a, ext_op, instr_retired, illegal;
  logic [1:0] npc_sel, alu_src_b;
  logic [2:0] alu_ctl;
  logic [3:0] state_dbg;
`ifdef MIPS_MC_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  mips_mc_ctrl #(.ALU_CTL_W(3), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .npc_sel(npc_sel),
    .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_op(ext_op), .alu_ctl(alu_ctl), .instr_retired(instr_retired),
    .illegal(illegal),
`ifdef MIPS_MC_PERF_CNT_EN
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt),
`endif
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Expected per-instruction summary; -1 means "not checked".
  typedef struct {
    int cycles, n_rw, n_mw, n_mr, n_pcw, n_irw;
    int wb_dst, wb_m2r, npc, alu_prev, alu_ret;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_pass = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // k: 0 addu 1 subu 2 slt 3 ori 4 lui 5 lw 6 sw 7 beq 8 j
  // f/m: cycles of mem_ready=0 in fetch / data access; z: zero seen by beq.
  task automatic run_instr(input int k, input int f, input int m, input bit z);
    bit   mr[$], zz[$];
    exp_t e;
    int   base [9] = '{4, 4, 4, 4, 4, 5, 4, 3, 3};
    int   alu_x[5] = '{0, 1, 3, 2, 4};
    logic [5:0] ops[9] = '{6'h00, 6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02};
    logic [5:0] fns[3] = '{6'h21, 6'h23, 6'h2A};
    bit   is_mem = (k == 5 || k == 6);
    e.cycles = base[k] + f + (is_mem ? m : 0);
    e.n_rw   = (k <= 5) ? 1 : 0;
    e.n_mw   = (k == 6) ? m + 1 : 0;
    e.n_mr   = f + 1 + ((k == 5) ? m + 1 : 0);
    e.n_irw  = 1;
    e.n_pcw  = 1 + ((k == 8) ? 1 : 0) + ((k == 7 && z) ? 1 : 0);
    e.npc    = (k == 8) ? 2 : ((k == 7 && z) ? 1 : 0);
    e.wb_dst = (k <= 2) ? 1 : ((k <= 5) ? 0 : -1);
    e.wb_m2r = (k == 5) ? 1 : ((k <= 4) ? 0 : -1);
    e.alu_prev = (k <= 4) ? alu_x[k] : -1;
    e.alu_ret  = (k == 7) ? 1 : -1;
    // per-cycle input plan: fetch, decode, then class-specific cycles
    repeat (f) begin mr.push_back(1'b0); zz.push_back(rb()); end
    mr.push_back(1'b1); zz.push_back(rb());
    mr.push_back(rb()); zz.push_back(rb());
    if (k <= 4) begin
      repeat (2) begin mr.push_back(rb()); zz.push_back(rb()); end
    end else if (is_mem) begin
      mr.push_back(rb()); zz.push_back(rb());
      repeat (m) begin mr.push_back(1'b0); zz.push_back(rb()); end
      mr.push_back(1'b1); zz.push_back(rb());
      if (k == 5) begin mr.push_back(rb()); zz.push_back(rb()); end
    end else begin
      mr.push_back(rb()); zz.push_back((k == 7) ? z : rb());
    end
    sb.push_back(e);
    opcode = ops[k];
    funct  = (k <= 2) ? fns[k] : 6'($urandom_range(0, 63));
    foreach (mr[i]) begin
      mem_ready = mr[i];
      zero      = zz[i];
      @(posedge clk); #1;
    end
  endtask

  // Monitor: accumulate outputs per instruction, compare on retire.
  int c_cyc, c_rw, c_mw, c_mr, c_pcw, c_irw, l_dst, l_m2r, l_npc, prev_alu;
  initial begin
    exp_t e;
    c_cyc = 0; c_rw = 0; c_mw = 0; c_mr = 0; c_pcw = 0; c_irw = 0;
    l_dst = -1; l_m2r = -1; l_npc = 0; prev_alu = -1;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        c_cyc++;
        if (reg_write) begin c_rw++; l_dst = int'(reg_dst); l_m2r = int'(mem_to_reg); end
        if (mem_write) c_mw++;
        if (mem_read)  c_mr++;
        if (ir_write)  c_irw++;
        if (pc_write)  begin c_pcw++; l_npc = int'(npc_sel); end
        if (instr_retired) begin
          if (sb.size() == 0) check("unexpected_retire", 1, 0);
          else begin
            e = sb.pop_front();
            check("latency", c_cyc, e.cycles);
            check("reg_write_cnt", c_rw, e.n_rw);
            check("mem_write_cnt", c_mw, e.n_mw);
            check("mem_read_cnt", c_mr, e.n_mr);
            check("ir_write_cnt", c_irw, e.n_irw);
            check("pc_write_cnt", c_pcw, e.n_pcw);
            check("npc_sel", l_npc, e.npc);
            check("illegal_low", int'(illegal), 0);
            if (e.wb_dst >= 0)   check("reg_dst", l_dst, e.wb_dst);
            if (e.wb_m2r >= 0)   check("mem_to_reg", l_m2r, e.wb_m2r);
            if (e.alu_prev >= 0) check("alu_ctl_exe", prev_alu, e.alu_prev);
            if (e.alu_ret >= 0)  check("alu_ctl_branch", int'(alu_ctl), e.alu_ret);
          end
          c_cyc = 0; c_rw = 0; c_mw = 0; c_mr = 0; c_pcw = 0; c_irw = 0;
          l_dst = -1; l_m2r = -1; l_npc = 0;
        end
        prev_alu = int'(alu_ctl);
      end
    end
  end

  task automatic check_quiet(input string nm);
    check({nm, "_mem_read"}, int'(mem_read), 0);
    check({nm, "_mem_write"}, int'(mem_write), 0);
    check({nm, "_wr_en"}, int'(pc_write | ir_write | reg_write), 0);
    check({nm, "_retired"}, int'(instr_retired), 0);
    check({nm, "_illegal"}, int'(illegal), 0);
  endtask

  task automatic trap_test(input logic [5:0] op, input logic [5:0] fn, input string nm);
    int bad = 0, ill = 0;
    opcode = op; funct = fn; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check({nm, "_illegal_set"}, int'(illegal), 1);
    repeat (20) begin
      mem_ready = rb(); zero = rb();
      @(negedge clk);
      if (pc_write | ir_write | mem_read | mem_write | reg_write | instr_retired) bad++;
      if (illegal) ill++;
      @(posedge clk); #1;
    end
    check({nm, "_no_writes"}, bad, 0);
    check({nm, "_illegal_held"}, ill, 20);
    rst = 1'b1; #1;
    check({nm, "_rst_clears"}, int'(illegal), 0);
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b0; #1;
    check({nm, "_fetch_after"}, int'(mem_read), 1);
    check({nm, "_illegal_after"}, int'(illegal), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset");
    check("reset_iord", int'(iord), 0);
    check("reset_srcb", int'(alu_src_b), 1);
    check("reset_alu", int'(alu_ctl), 0);
    rst = 1'b0; mon_en = 1'b1;
    // directed cases first, then a random stream
    run_instr(0, 0, 0, 1'b0);
    run_instr(5, 0, 2, 1'b0);
    run_instr(7, 0, 0, 1'b1);
    run_instr(7, 0, 0, 1'b0);
    run_instr(8, 1, 0, 1'b0);
    run_instr(6, 0, 3, 1'b0);
    for (int i = 0; i < 40; i++)
      run_instr($urandom_range(0, 8), $urandom_range(0, 2), $urandom_range(0, 3), rb());
    check("sb_drained", sb.size(), 0);
    mon_en = 1'b0;

    // reset while a store is waiting on memory
    opcode = 6'h2B; mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("sw_wait_mem_write", int'(mem_write), 1);
    #1 rst = 1'b1; #1;
    check("rst_drops_mem_write", int'(mem_write), 0);
    check("rst_mem_read", int'(mem_read), 0);
    check("rst_iord", int'(iord), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_mem_read", int'(mem_read), 1);
    check("post_rst_mem_write", int'(mem_write), 0);
    check("post_rst_ir_write", int'(ir_write), 0);
    @(posedge clk); #1;

    trap_test(6'h3F, 6'h00, "trap_op3f");
    trap_test(6'h00, 6'h20, "trap_badfunct");

`ifdef MIPS_MC_PERF_CNT_EN
    // j, ori, sw back to back without stalls
    mem_ready = 1'b1;
    opcode = 6'h02; repeat (3) @(posedge clk); #1;
    opcode = 6'h0D; repeat (4) @(posedge clk); #1;
    opcode = 6'h2B; repeat (3) @(posedge clk); #1;
    check("perf_cycle_cnt", int'(cycle_cnt), 10);
    check("perf_last_retire", int'(instr_retired), 1);
    @(posedge clk); #1;
    check("perf_instr_cnt", int'(instr_cnt), 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multi-cycle successor to the single-cycle MIPS controller: Moore FSM sequencing a shared-memory, multi-cycle datapath.
- Adds memory wait handshake, branch/jump/lui/slt, illegal-opcode trap and instruction-retire pulse.
- Parametrised ALU-control width.
- Sits beside the multi-cycle datapath in the MIPS top; consumes IR opcode/funct plus ALU zero.

Parameters:
- ALU_CTL_W, 3, alu_ctl width; must be >=3, upper bits driven 0.
- CNT_W, 32, perf counter width (used only with PERF_CNT_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_write  out  1  PC load enable.
- npc_sel  out  2  next-PC source: 00 ALU result, 01 ALUOut (branch target), 10 jump target.
- ir_write  out  1  IR load enable.
- iord  out  1  memory address source: 0 PC, 1 ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- reg_write  out  1  register-file write enable.
- reg_dst  out  1  destination register: 1 rd, 0 rt.
- mem_to_reg  out  1  writeback source: 1 MDR, 0 ALUOut.
- alu_src_a  out  1  ALU A input: 0 PC, 1 rs.
- alu_src_b  out  2  ALU B input: 00 rt, 01 const 4, 10 ext imm, 11 sext imm<<2.
- ext_op  out  1  immediate extension: 1 sign, 0 zero.
- alu_ctl  out  ALU_CTL_W  ALU operation: 0 add, 1 sub, 2 or, 3 slt, 4 lui.
- instr_retired  out  1  one-cycle pulse on the last cycle of each instruction.
- illegal  out  1  sticky trap flag.
- state_dbg  out  4  current state, for debug.

Behaviour:
- Supported instructions: addu (0/0x21), subu (0/0x23), slt (0/0x2A), ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, j 0x02. Any other opcode/funct is illegal.
- States:
  - FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctl=add. ir_write, pc_write (npc_sel=00) asserted only when mem_ready. Stays in FETCH while !mem_ready.
  - DECODE: alu_src_a=0, alu_src_b=11, ext_op=1, add; computes branch target.
    - lw/sw -> MEM_ADDR; R-type -> EXE_R; ori/lui -> EXE_I; beq -> BRANCH; j -> JUMP; else -> TRAP.
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, ext_op=1, add. lw -> MEM_RD; sw -> MEM_WR.
  - MEM_RD: mem_read=1, iord=1. Waits for mem_ready, then -> MEM_WB.
  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; retire; -> FETCH.
  - MEM_WR: mem_write=1, iord=1. Waits for mem_ready; retire in the mem_ready cycle; -> FETCH.
  - EXE_R: alu_src_a=1, alu_src_b=00, alu_ctl from funct. -> ALU_WB.
  - EXE_I: alu_src_a=1, alu_src_b=10, ext_op=0, alu_ctl or (ori) or lui. -> ALU_WB.
  - ALU_WB: reg_write=1, mem_to_reg=0, reg_dst=1 for R-type else 0; retire; -> FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, sub, npc_sel=01, pc_write=zero; retire; -> FETCH.
  - JUMP: pc_write=1, npc_sel=10; retire; -> FETCH.
  - TRAP: all enables and requests 0, illegal=1. Absorbing state; only rst exits.
- Latency: R/I types 4 cycles, lw 5, sw 4, beq 3, j 3, plus extra cycles per !mem_ready in FETCH/MEM_RD/MEM_WR.
- Outputs are combinational from state (plus mem_ready/zero gating); state is registered.
- opcode/funct must be read only after DECODE; IR is stable from then on.
- Reset, including mid-instruction: state=FETCH. While rst=1, every enable/request output is 0, illegal=0, instr_retired=0, and other outputs hold the FETCH values. No memory request is left pending: a write in flight is dropped.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.

Optional Feature:
- Macro MIPS_MC_PERF_CNT_EN.
- Defined: adds outputs cycle_cnt[CNT_W] (increments every cycle out of reset, saturates never, wraps at 2^CNT_W) and instr_cnt[CNT_W] (increments on instr_retired). Both clear on rst; both freeze in TRAP.
- Undefined: ports and counters absent; no other behaviour change.

Decomposition:
- Package mips_mc_pkg: opcode/funct constants, state enum (4-bit), alu_ctl codes, npc_sel and alu_src_b codes.
- One sub-module, mips_mc_decode: combinational opcode/funct classifier producing instruction class, R-type alu_ctl and legal flag.

Test Plan:
- addu with mem_ready=1 always -> states FETCH, DECODE, EXE_R, ALU_WB; alu_ctl=0, reg_dst=1, one instr_retired pulse in cycle 4.
- lw with mem_ready low for 2 cycles in MEM_RD -> 7 cycles total; reg_write with mem_to_reg=1 exactly once.
- beq zero=1 -> pc_write=1, npc_sel=01 in BRANCH; beq zero=0 -> pc_write=0; both retire after 3 cycles.
- opcode 0x3F -> TRAP after DECODE, illegal=1 held 20 cycles, no writes; rst pulse -> FETCH, illegal=0.
- rst asserted during MEM_WR with mem_ready=0 -> mem_write drops the same cycle; after release, FETCH with mem_read=1.
- With MIPS_MC_PERF_CNT_EN: run j, ori, sw (all mem_ready=1) -> instr_cnt=3, cycle_cnt=10.
